// File: rtl/uart_tx_fifo_if.sv
// Bus/transmitter bundle for the UART transmit FIFO.
// Overflow signals exist only with UART_TX_FIFO_OVERFLOW_FLAG_EN.
interface uart_tx_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic [7:0]          wr_data;
  logic                wr_strobe;
  logic                full;
  logic                empty;
  logic [DEPTH_LOG2:0] level;
  logic [7:0]          tx_data;
  logic                tx_latch;
  logic                tx_busy;
`ifdef UART_TX_FIFO_OVERFLOW_FLAG_EN
  logic                overflow;
  logic                clear_overflow;

  modport master (
    output wr_data, wr_strobe, tx_busy,
    output clear_overflow,
    input  full, empty, level,
    input  tx_data, tx_latch, overflow
  );

  modport slave (
    input  wr_data, wr_strobe, tx_busy,
    input  clear_overflow,
    output full, empty, level,
    output tx_data, tx_latch, overflow
  );
`else
  modport master (
    output wr_data, wr_strobe, tx_busy,
    input  full, empty, level,
    input  tx_data, tx_latch
  );

  modport slave (
    input  wr_data, wr_strobe, tx_busy,
    output full, empty, level,
    output tx_data, tx_latch
  );
`endif
endinterface

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO draining into a UART transmitter via latch/busy.
// Optional sticky drop flag: define UART_TX_FIFO_OVERFLOW_FLAG_EN.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input logic            clk,
  input logic            rst,
  uart_tx_fifo_if.slave  bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL =
    (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMED     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t                state;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   level;
  logic [DEPTH_LOG2:0]   level_nxt;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic [7:0]            tx_data;
  logic                  tx_latch;

  // A push while full is dropped even if a pop happens the same cycle.
  assign push = bus.wr_strobe && !full;
  assign pop  = (state == IDLE) && !empty && !bus.tx_busy;

  // Next occupancy; simultaneous push and pop cancel out.
  always_comb begin
    level_nxt = level;
    case ({push, pop})
      2'b10:   level_nxt = level + 1'b1;
      2'b01:   level_nxt = level - 1'b1;
      default: level_nxt = level;
    endcase
  end

  // Storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.wr_data;
  end

  // Pointers, occupancy and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level_nxt;
      full  <= (level_nxt == FULL_LVL);
      empty <= (level_nxt == '0);
    end
  end

  // Drain FSM: one latch per byte, then wait out the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tx_data  <= 8'h00;
      tx_latch <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            tx_data  <= mem[rd_ptr];
            tx_latch <= 1'b1;
            state    <= ARMED;
          end
        end
        ARMED: begin
          tx_latch <= 1'b0;
          state    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          // No busy response: treat the byte as sent.
          state <= bus.tx_busy ? WAIT_DONE : IDLE;
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.level    = level;
  assign bus.tx_data  = tx_data;
  assign bus.tx_latch = tx_latch;

`ifdef UART_TX_FIFO_OVERFLOW_FLAG_EN
  logic overflow;

  // Sticky drop flag; a new drop beats a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (bus.wr_strobe && full) begin
      overflow <= 1'b1;
    end else if (bus.clear_overflow) begin
      overflow <= 1'b0;
    end
  end

  assign bus.overflow = overflow;
`endif
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Transmit byte buffer that sits between the bus-write trigger and the UART transmitter. It accepts single-cycle byte pushes from the bus interface and stores them in a circular FIFO. It drains the FIFO into the transmitter one byte at a time, using the transmitter's latch/busy handshake, so the CPU can write a burst of bytes without polling the busy flag between each one.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth; depth = 2**DEPTH_LOG2 = 16 entries; legal range 1..8.

Ports:
clk  input  1  system clock (16 MHz)
rst  input  1  asynchronous reset, active-high
wr_data  input  8  byte to enqueue
wr_strobe  input  1  single-cycle push request, already edge-triggered upstream
full  output  1  FIFO holds DEPTH entries
empty  output  1  FIFO holds 0 entries
level  output  DEPTH_LOG2+1  current entry count, 0..DEPTH
tx_data  output  8  byte presented to the transmitter data input
tx_latch  output  1  one-cycle latch pulse to the transmitter
tx_busy  input  1  transmitter busy; rises the cycle after an accepted latch, stays high for the full 12-bit frame
overflow  output  1  sticky drop flag (present only with the optional feature)
clear_overflow  input  1  clears overflow (present only with the optional feature)

Behaviour:
- Reset (async assert, sync release): wr_ptr=0, rd_ptr=0, level=0, empty=1, full=0, tx_data=0, tx_latch=0, state=IDLE, overflow=0. FIFO RAM contents are not cleared.
- Storage: DEPTH x 8 register array. Pointers are DEPTH_LOG2 bits wide and wrap modulo DEPTH. level is a separate DEPTH_LOG2+1-bit counter; full=(level==DEPTH), empty=(level==0). full, empty and level are all registered.
- Push: wr_strobe && !full writes wr_data at wr_ptr, increments wr_ptr, and increments level. wr_strobe && full drops the byte; pointers and level are unchanged.
- Pop happens only in the IDLE->ARMED transition (below).
- Push and pop in the same cycle: both pointers advance and level is unchanged. A push while full is never rescued by a same-cycle pop; it is dropped.
- Drain FSM, 2-bit state:
  - IDLE: if !empty && !tx_busy, register tx_data<=mem[rd_ptr] and tx_latch<=1, advance rd_ptr, decrement level, go to ARMED. Otherwise stay.
  - ARMED: tx_latch is high for exactly this cycle. Register tx_latch<=0 and go to WAIT_BUSY unconditionally.
  - WAIT_BUSY: if tx_busy go to WAIT_DONE. Otherwise go to IDLE; the byte counts as delivered and is not retried.
  - WAIT_DONE: stay while tx_busy; go to IDLE when tx_busy==0.
- tx_data holds its value after the latch until the next pop.
- Latency: strobe sampled in cycle N, FIFO empty, FSM in IDLE, tx_busy low -> tx_latch high in cycle N+2.
- Back-to-back bytes: after tx_busy falls, the next tx_latch rises 2 cycles later (WAIT_DONE->IDLE, then IDLE registers the latch). The transmitter sees no second latch while busy.
- tx_latch is never high in two consecutive cycles.
- Reset mid-operation returns everything to the reset values immediately. A frame already latched into the transmitter is not aborted by this block.

Optional Feature:
UART_TX_FIFO_OVERFLOW_FLAG_EN:
- Defined: overflow port exists. overflow is set the cycle after a wr_strobe arrives while full, and stays set until clear_overflow or rst. If set and clear happen in the same cycle, set wins. The bus side exposes overflow as status bit 2.
- Undefined: the overflow and clear_overflow ports and their logic are absent. Dropped pushes are silent.

Test Plan:
- Reset, then a single push 0x41 with tx_busy modelled 1 cycle after latch for 12x139 cycles -> tx_latch high exactly 2 cycles after the strobe with tx_data=0x41; level 1 then 0; empty=1 at the end.
- Push 3 bytes (0x55, 0xAA, 0x0F) in consecutive cycles -> level peaks at 2 (the first byte pops immediately); three latches in order 0x55, 0xAA, 0x0F; each latch 2 cycles after tx_busy falls; no latch while tx_busy=1.
- Hold tx_busy=1 and push 17 bytes with DEPTH_LOG2=4 -> full=1 and level=16 after byte 16; byte 17 dropped; overflow=1 with the feature enabled; release tx_busy -> 16 bytes drained in order and byte 17 never appears.
- FIFO at 5 entries, push in the same cycle as an IDLE pop -> level stays 5; rd_ptr and wr_ptr both advance; data order preserved across pointer wrap (push 20 bytes total through a 16-deep FIFO).
- Assert rst while in WAIT_DONE with 4 entries queued -> next cycle level=0, empty=1, tx_latch=0, state IDLE; no further latch after tx_busy falls.
- Feature enabled: trigger overflow, then assert clear_overflow together with another full-push -> overflow stays 1; clear_overflow alone -> overflow=0 the next cycle.
